// File: rtl/ram_dp_init.sv
// ram_dp_init -- simple-dual-port synchronous RAM with byte-lane writes and an
// init sweep that loads INIT_VAL into every word after reset or on request.
//
// Ports
//   clk     clock, all state on rising edge
//   rst     asynchronous active-high reset
//   clear   1-cycle request to re-run the init sweep
//   busy    high while the init sweep runs; read/write ports ignored
//   we      write request
//   waddr   write address
//   wdata   write data
//   be      byte-lane enables, lane i covers wdata[i*BYTE_W +: BYTE_W]
//   re      read request
//   raddr   read address
//   rdata   read data, holds until the next accepted read
//   rvalid  1-cycle strobe: rdata was updated on the preceding edge
//
// Storage is split into NB independent lane arrays. This lets a byte enable
// gate a lane's write port directly, with no read-modify-write.

module ram_dp_init_lane #(
    parameter int LANE_W   = 8,
    parameter int ADDR_W   = 2,
    parameter int RDW_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [LANE_W-1:0] wdata,
    input  logic              ren,
    input  logic [ADDR_W-1:0] raddr,
    output logic [LANE_W-1:0] rdata
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [LANE_W-1:0] mem [DEPTH];

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wen) mem[waddr] <= wdata;
    end

    // Write-first mode forwards this lane's incoming data on an address
    // collision. Read-first mode returns the stored word, which the
    // non-blocking write has not changed yet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata <= '0;
        else if (ren)
            rdata <= (RDW_MODE != 0 && wen && waddr == raddr) ? wdata : mem[raddr];
    end
endmodule

module ram_dp_init #(
    parameter int                DATA_W   = 8,
    parameter int                BYTE_W   = 8,
    parameter int                ADDR_W   = 2,
    parameter int                RDW_MODE = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    output logic                       busy,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [DATA_W/BYTE_W-1:0]   be,
    input  logic                       re,
    input  logic [ADDR_W-1:0]          raddr,
    output logic [DATA_W-1:0]          rdata,
    output logic                       rvalid
);
    localparam int NB = DATA_W / BYTE_W;
    localparam logic [NB-1:0][BYTE_W-1:0] INIT_LANES = INIT_VAL;

    typedef enum logic {INIT, READY} state_t;

    state_t            state, next_state;
    logic [ADDR_W-1:0] ptr, next_ptr;
    logic              rd_acc;

    logic [NB-1:0][BYTE_W-1:0] wdata_lanes;
    logic [NB-1:0][BYTE_W-1:0] lane_wdata;
    logic [NB-1:0][BYTE_W-1:0] rdata_lanes;
    logic [NB-1:0]             lane_wen;
    logic [ADDR_W-1:0]         lane_waddr;

    // ---------------------------------------------------------------
    // Init sweep FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            state <= next_state;
            ptr   <= next_ptr;
        end
    end

    always_comb begin
        next_state = state;
        next_ptr   = ptr;
        case (state)
            INIT: begin
                // clear restarts the sweep. It wins even on the final sweep
                // edge, so busy always lasts a full DEPTH edges after it.
                if (clear)
                    next_ptr = '0;
                else if (ptr == {ADDR_W{1'b1}})
                    next_state = READY;
                else
                    next_ptr = ptr + 1'b1;
            end
            READY: begin
                if (clear) begin
                    next_state = INIT;
                    next_ptr   = '0;
                end
            end
            default: begin
                next_state = INIT;
                next_ptr   = '0;
            end
        endcase
    end

    assign busy = (state == INIT);

    // ---------------------------------------------------------------
    // Port muxing: the sweep owns the write port while busy
    // ---------------------------------------------------------------
    assign wdata_lanes = wdata;
    assign rd_acc      = !busy && re;
    assign lane_waddr  = busy ? ptr : waddr;

    always_comb begin
        lane_wen   = '0;
        lane_wdata = wdata_lanes;
        if (busy) begin
            lane_wen   = '1;
            lane_wdata = INIT_LANES;
        end else if (we) begin
            lane_wen = be;
        end
    end

    genvar i;
    generate
        for (i = 0; i < NB; i++) begin : g_lane
            ram_dp_init_lane #(
                .LANE_W   (BYTE_W),
                .ADDR_W   (ADDR_W),
                .RDW_MODE (RDW_MODE)
            ) u_lane (
                .clk   (clk),
                .rst   (rst),
                .wen   (lane_wen[i]),
                .waddr (lane_waddr),
                .wdata (lane_wdata[i]),
                .ren   (rd_acc),
                .raddr (raddr),
                .rdata (rdata_lanes[i])
            );
        end
    endgenerate

    assign rdata = rdata_lanes;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rvalid <= 1'b0;
        else     rvalid <= rd_acc;
    end
endmodule

// File: tb/tb_ram_dp_init.sv
// Self-checking bench for ram_dp_init. Two instances run in lockstep on the
// same stimulus: one read-first and one write-first. A spec-level model
// tracks the sweep state and the memory contents. Expected read words are
// pushed to a per-instance queue on the accepting edge and popped at the
// next negedge, where rvalid must be high.
module tb_ram_dp_init;
    localparam logic [15:0] IV = 16'hA5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0, we = 1'b0, re = 1'b0;
    logic [1:0]  waddr = '0, raddr = '0, be = '0;
    logic [15:0] wdata = '0;
    logic        busy0, busy1, rvalid0, rvalid1;
    logic [15:0] rdata0, rdata1;

    always #5 clk = ~clk;

    ram_dp_init #(.DATA_W(16), .BYTE_W(8), .ADDR_W(2), .RDW_MODE(0), .INIT_VAL(IV)) u_dut0 (
        .clk(clk), .rst(rst), .clear(clear), .busy(busy0), .we(we), .waddr(waddr),
        .wdata(wdata), .be(be), .re(re), .raddr(raddr), .rdata(rdata0), .rvalid(rvalid0));

    ram_dp_init #(.DATA_W(16), .BYTE_W(8), .ADDR_W(2), .RDW_MODE(1), .INIT_VAL(IV)) u_dut1 (
        .clk(clk), .rst(rst), .clear(clear), .busy(busy1), .we(we), .waddr(waddr),
        .wdata(wdata), .be(be), .re(re), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1));

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [15:0] mem_m [4];
    logic        m_init = 1'b1;
    logic [1:0]  m_ptr  = '0;
    logic [15:0] q0[$], q1[$];
    logic [15:0] last0 = '0, last1 = '0;
    logic        chk_en = 1'b0;

    // Applies one clock edge to the model, using the inputs sampled there.
    task automatic model_edge();
        logic [15:0] old, merged;
        if (rst) begin
            m_init = 1'b1; m_ptr = '0;
            return;
        end
        if (m_init) begin
            mem_m[m_ptr] = IV;
            if (clear)              m_ptr = '0;
            else if (m_ptr == 2'd3) m_init = 1'b0;
            else                    m_ptr = m_ptr + 2'd1;
        end else begin
            merged = mem_m[waddr];
            for (int l = 0; l < 2; l++)
                if (be[l]) merged[l*8 +: 8] = wdata[l*8 +: 8];
            if (re) begin
                old = mem_m[raddr];
                q0.push_back(old);
                q1.push_back((we && waddr == raddr) ? merged : old);
            end
            if (we) mem_m[waddr] = merged;
            if (clear) begin
                m_init = 1'b1; m_ptr = '0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic e0, e1;
            chk("busy0", 32'(busy0), 32'(m_init));
            chk("busy1", 32'(busy1), 32'(m_init));
            e0 = (q0.size() > 0);
            e1 = (q1.size() > 0);
            chk("rvalid0", 32'(rvalid0), 32'(e0));
            chk("rvalid1", 32'(rvalid1), 32'(e1));
            if (e0) last0 = q0.pop_front();
            if (e1) last1 = q1.pop_front();
            chk("rdata0", 32'(rdata0), 32'(last0));
            chk("rdata1", 32'(rdata1), 32'(last1));
        end
    end

    // ---------------- drivers ----------------
    task automatic step(input logic we_i, input logic [1:0] wa, input logic [15:0] wd,
                        input logic [1:0] be_i, input logic re_i, input logic [1:0] ra,
                        input logic clr);
        we = we_i; waddr = wa; wdata = wd; be = be_i; re = re_i; raddr = ra; clear = clr;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        step(1'b0, 2'd0, 16'h0, 2'b00, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic rd(input logic [1:0] a);
        step(1'b0, 2'd0, 16'h0, 2'b00, 1'b1, a, 1'b0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d, input logic [1:0] b);
        step(1'b1, a, d, b, 1'b0, 2'd0, 1'b0);
    endtask

    // Counts edges until busy drops, bounded so a stuck busy cannot hang the run.
    task automatic busy_len(input string tag, input logic poke);
        int n = 0;
        do begin
            step(poke, 2'(n), 16'hDEAD, 2'b11, poke, 2'(n), 1'b0);
            n++;
        end while (busy0 && n < 20);
        chk(tag, 32'(n), 32'd4);
    endtask

    initial begin
        // ---- 1: reset and initial sweep ----
        #1 rst = 1'b1;
        chk_en = 1'b1;
        repeat (3) idle();
        rst = 1'b0;
        chk("busy_after_rst", 32'(busy0), 32'd1);
        busy_len("busy_len_reset", 1'b0);
        for (int i = 0; i < 4; i++) rd(2'(i));
        idle();

        // ---- 2: byte-lane write merge ----
        wr(2'd2, 16'h1234, 2'b11);
        wr(2'd2, 16'hFF00, 2'b10);
        rd(2'd2);
        idle();
        chk("lane_merge", 32'(rdata0), 32'h0000FF34);

        // ---- 3: read-during-write on the same address ----
        wr(2'd1, 16'h0001, 2'b11);
        step(1'b1, 2'd1, 16'hBEEF, 2'b11, 1'b1, 2'd1, 1'b0);
        rd(2'd1);
        idle();

        // ---- 4: clear with ignored traffic during the sweep ----
        wr(2'd0, 16'h1111, 2'b11);
        wr(2'd3, 16'h2222, 2'b11);
        step(1'b1, 2'd0, 16'h3333, 2'b11, 1'b1, 2'd3, 1'b1);
        busy_len("busy_len_clear", 1'b1);
        for (int i = 0; i < 4; i++) rd(2'(i));
        idle();
        // Second clear arrives on sweep edge 2.
        step(1'b0, 2'd0, 16'h0, 2'b00, 1'b0, 2'd0, 1'b1);
        idle();
        step(1'b0, 2'd0, 16'h0, 2'b00, 1'b0, 2'd0, 1'b1);
        busy_len("busy_len_reclear", 1'b0);
        rd(2'd2);
        idle();

        // ---- 5: reset during the sweep ----
        step(1'b0, 2'd0, 16'h0, 2'b00, 1'b0, 2'd0, 1'b1);
        idle();
        idle();
        rst = 1'b1;
        #1;
        chk("async_rdata0", 32'(rdata0), 32'd0);
        chk("async_rdata1", 32'(rdata1), 32'd0);
        chk("async_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
        chk("async_busy", 32'({busy0, busy1}), 32'd3);
        last0 = '0; last1 = '0;
        m_init = 1'b1; m_ptr = '0;
        idle();
        idle();
        rst = 1'b0;
        busy_len("busy_len_rst_mid", 1'b0);
        for (int i = 0; i < 4; i++) rd(2'(i));

        // ---- 6: back-to-back reads with a concurrent write ----
        wr(2'd3, 16'h3C3C, 2'b11);
        rd(2'd3);
        step(1'b1, 2'd0, 16'hC0DE, 2'b01, 1'b1, 2'd0, 1'b0);
        rd(2'd1);
        idle();
        rd(2'd0);
        idle();

        // ---- random traffic in READY ----
        for (int k = 0; k < 60; k++)
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 1'b0);
        idle();
        idle();
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
